// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter: shares one single-port sync instruction RAM between the fetch
// stage and a loader/debug port; loader wins except when its burst limit is reached.
module imem_port_arbiter #(
   parameter int ADDR_W   = 6,
   parameter int DATA_W   = 32,
   parameter int LD_BURST = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              fetch_req,
   input  logic [31:0]       fetch_pc,
   output logic              fetch_stall,
   output logic              fetch_valid,
   output logic [DATA_W-1:0] fetch_instr,
   output logic              fetch_err,
   input  logic              ld_req,
   input  logic              ld_we,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_wdata,
   output logic              ld_gnt,
   output logic              ld_rvalid,
   output logic [DATA_W-1:0] ld_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);
   localparam int BW = $clog2(LD_BURST + 1);
   typedef enum logic [1:0] {NONE, FETCH, FETCH_OOR, LD_RD} rsp_t;
   rsp_t rsp_q, rsp_d;
   logic [BW-1:0] burst_q, burst_d;
   logic mis_q, mis_d, fetch_gnt, oor, burst_full;
   always_comb begin
      oor = |fetch_pc[31:ADDR_W+2];
      burst_full = (burst_q == BW'(LD_BURST));
      fetch_gnt = ~reset & fetch_req & (~ld_req | burst_full);
      ld_gnt = ~reset & ld_req & ~fetch_gnt;
      fetch_stall = ~reset & fetch_req & ~fetch_gnt;
      // an out-of-range fetch still consumes its grant but never touches the RAM
      mem_en = ld_gnt | (fetch_gnt & ~oor);
      mem_we = ld_gnt & ld_we;
      mem_addr = fetch_gnt ? fetch_pc[ADDR_W+1:2] : ld_gnt ? ld_addr : '0;
      mem_wdata = ld_gnt ? ld_wdata : '0;
      burst_d = (~fetch_req | fetch_gnt) ? '0 : (ld_gnt & ~burst_full) ? burst_q + 1'b1 : burst_q;
      rsp_d = fetch_gnt ? (oor ? FETCH_OOR : FETCH) : (ld_gnt & ~ld_we) ? LD_RD : NONE;
      mis_d = fetch_gnt & (|fetch_pc[1:0]);
      fetch_valid = (rsp_q == FETCH) | (rsp_q == FETCH_OOR);
      fetch_instr = (rsp_q == FETCH) ? mem_rdata : '0;
      fetch_err = (rsp_q == FETCH_OOR) | ((rsp_q == FETCH) & mis_q);
      ld_rvalid = (rsp_q == LD_RD);
      ld_rdata = ld_rvalid ? mem_rdata : '0;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rsp_q   <= NONE;
         burst_q <= '0;
         mis_q   <= 1'b0;
      end else begin
         rsp_q   <= rsp_d;
         burst_q <= burst_d;
         mis_q   <= mis_d;
      end
   end
endmodule
